// File: rtl/varredura_tdm_if.sv
// Bundle between the scan controller and the MUX/DEMUX link side.
// The master drives the select bus and the reassembled word; the slave drives start and the line.
interface varredura_tdm_if;
  logic       start;
  logic       linha;
  logic [1:0] S;
  logic [3:0] dado;
  logic       busy;
  logic       valid;

  modport master (input start, linha, output S, dado, busy, valid);
  modport slave  (output start, linha, input S, dado, busy, valid);
endinterface

// File: rtl/varredura_tdm.sv
// TDM scan controller: steps S over channels 0..3, HOLD cycles each, and samples linha into a 4-bit word.
// Optional macro VARREDURA_CONTINUA_EN: after the first start, frames run back to back until rst.
module varredura_tdm #(
  parameter int HOLD = 2
) (
  input  logic             clk,
  input  logic             rst,
  varredura_tdm_if.master  bus
);
  localparam int             DW   = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [DW-1:0]  LAST = DW'(HOLD - 1);

  if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
    $error("varredura_tdm: HOLD must be within 1..255");
  end

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t        state;
  logic [1:0]    ch;
  logic [DW-1:0] dw;
  logic [3:0]    buf_q;
  logic [3:0]    dado_q;
  logic          busy_q;
  logic          valid_q;

  // ch doubles as S: it is zero outside SCAN because it wraps 3->0 on the final sample.
  assign bus.S     = ch;
  assign bus.dado  = dado_q;
  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ch      <= '0;
      dw      <= '0;
      buf_q   <= '0;
      dado_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= SCAN;
            busy_q <= 1'b1;
            ch     <= '0;
            dw     <= '0;
          end
        end
        SCAN: begin
          if (dw == LAST) begin
            buf_q[ch] <= bus.linha;
            dw        <= '0;
            ch        <= ch + 2'd1;
            if (ch == 2'd3) begin
              // the channel-3 sample bypasses buf_q so it lands in dado on this same edge
              state   <= DONE;
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
              dado_q  <= {bus.linha, buf_q[2:0]};
            end
          end else begin
            dw <= dw + 1'b1;
          end
        end
        DONE: begin
`ifdef VARREDURA_CONTINUA_EN
          state  <= SCAN;
          busy_q <= 1'b1;
          ch     <= '0;
          dw     <= '0;
`else
          state  <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_varredura_tdm.sv
// Bench for varredura_tdm: two instances (HOLD=2, HOLD=1) behind a behavioural MUX/DEMUX,
// checked every cycle against a frame-timing reference plus directed latency/word checks.
module tb_varredura_tdm;
`ifdef VARREDURA_CONTINUA_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_en = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  varredura_tdm_if ifa ();
  varredura_tdm_if ifb ();

  logic       st [2];
  logic [3:0] dv [2];
  logic [1:0] so [2];
  logic [3:0] doo[2];
  logic       bo [2];
  logic       vo [2];
  logic       lo [2];

  // MUX: the link line is the D bit selected by the current S
  assign ifa.start = st[0];
  assign ifb.start = st[1];
  assign ifa.linha = dv[0][ifa.S];
  assign ifb.linha = dv[1][ifb.S];
  assign so[0] = ifa.S;    assign so[1] = ifb.S;
  assign doo[0] = ifa.dado; assign doo[1] = ifb.dado;
  assign bo[0] = ifa.busy; assign bo[1] = ifb.busy;
  assign vo[0] = ifa.valid; assign vo[1] = ifb.valid;
  assign lo[0] = ifa.linha; assign lo[1] = ifb.linha;

  varredura_tdm #(.HOLD(2)) u_dut  (.clk(clk), .rst(rst), .bus(ifa));
  varredura_tdm #(.HOLD(1)) u_dut1 (.clk(clk), .rst(rst), .bus(ifb));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: k is the cycle index within a frame (0 = idle, 1..4H scan, 4H+1 done).
  for (genvar j = 0; j < 2; j++) begin : g_ref
    localparam int HH = (j == 0) ? 2 : 1;
    int         k  = 0;
    logic [3:0] mb = '0;
    logic [3:0] md = '0;

    always @(posedge clk) begin
      if (rst) begin
        k  <= 0;
        mb <= '0;
        md <= '0;
      end else if (k == 0) begin
        if (st[j]) k <= 1;
      end else if (k <= 4*HH) begin
        if (k % HH == 0) mb[2'(k/HH - 1)] <= dv[j][2'(k/HH - 1)];
        if (k == 4*HH) md <= {dv[j][3], mb[2:0]};
        k <= k + 1;
      end else begin
        k <= CONT ? 1 : 0;
      end
    end

    always @(negedge clk) begin
      if (chk_en) begin
        chk($sformatf("u%0d.S", j),     32'(so[j]),  (k >= 1 && k <= 4*HH) ? 32'((k-1)/HH) : 32'd0);
        chk($sformatf("u%0d.busy", j),  32'(bo[j]),  32'(k >= 1 && k <= 4*HH));
        chk($sformatf("u%0d.valid", j), 32'(vo[j]),  32'(k == 4*HH + 1));
        chk($sformatf("u%0d.dado", j),  32'(doo[j]), 32'(md));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      st[0] = 1'($urandom); st[1] = 1'($urandom);
      dv[0] = 4'($urandom); dv[1] = 4'($urandom);
      tick();
    end
    st[0] = 1'b0; st[1] = 1'b0;
    rst = 1'b0;
  endtask

  // Launch a frame on instance j and report the cycle valid arrives plus the DEMUX picture.
  task automatic run_lat(input int j, input bit hold, output int lat, output logic [3:0] dd,
                         output logic [3:0] ymask, output int yhits);
    lat = -1; dd = 'x; ymask = '0; yhits = 0;
    st[j] = 1'b1;
    tick();
    if (!hold) st[j] = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (bo[j] && lo[j]) begin
        ymask |= 4'(1) << so[j];
        yhits++;
      end
      if (vo[j] && lat < 0) begin
        lat = c;
        dd  = doo[j];
        if (!hold) break;
      end
      if (hold && c == 30) break;
      tick();
    end
    st[j] = 1'b0;
  endtask

  int         lat, yh, nv;
  logic [3:0] dd, ym;
  int         vc[$];
  logic [3:0] vd[$];

  initial begin
    st[0] = 1'b0; st[1] = 1'b0; dv[0] = '0; dv[1] = '0;
    tick();
    chk_en = 1'b1;

    // reset with random inputs
    do_reset();
    chk("rst.S", 32'(so[0]), 0);
    chk("rst.dado", 32'(doo[0]), 0);
    chk("rst.busy", 32'(bo[0]), 0);
    chk("rst.valid", 32'(vo[0]), 0);

    // basic loopback, HOLD=2
    do_reset();
    dv[0] = 4'b1010;
    run_lat(0, 1'b0, lat, dd, ym, yh);
    chk("h2.latency", 32'(lat), 9);
    chk("h2.dado", 32'(dd), 32'b1010);

    // HOLD=1, DEMUX walking one on bits 1 and 2
    do_reset();
    dv[1] = 4'b0110;
    run_lat(1, 1'b0, lat, dd, ym, yh);
    chk("h1.latency", 32'(lat), 5);
    chk("h1.dado", 32'(dd), 32'b0110);
    chk("h1.demux_mask", 32'(ym), 32'b0110);
    chk("h1.demux_hits", 32'(yh), 2);

    // start held high: first valid still at cycle 9, restart timing covered by the reference
    do_reset();
    dv[0] = 4'b0011;
    run_lat(0, 1'b1, lat, dd, ym, yh);
    chk("hold.latency", 32'(lat), 9);
    chk("hold.dado", 32'(dd), 32'b0011);

    // mid-frame reset at cycle 5
    do_reset();
    dv[0] = 4'b1111;
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid.S", 32'(so[0]), 0);
    chk("mid.busy", 32'(bo[0]), 0);
    chk("mid.dado", 32'(doo[0]), 0);
    nv = 0;
    for (int c = 0; c < 12; c++) begin
      if (vo[0]) nv++;
      tick();
    end
    chk("mid.no_valid", 32'(nv), 0);
    chk("mid.dado_held", 32'(doo[0]), 0);

`ifdef VARREDURA_CONTINUA_EN
    // continuous frames; D changes during frame 2 after channel 0 is sampled
    do_reset();
    dv[0] = 4'b0101;
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    for (int c = 1; c <= 28; c++) begin
      if (c == 12) dv[0] = 4'b1100;
      if (vo[0]) begin
        vc.push_back(c);
        vd.push_back(doo[0]);
      end
      tick();
    end
    chk("cont.n_valid", 32'(vc.size()), 3);
    if (vc.size() == 3) begin
      chk("cont.v1", 32'(vc[0]), 9);
      chk("cont.v2", 32'(vc[1]), 18);
      chk("cont.v3", 32'(vc[2]), 27);
      chk("cont.d1", 32'(vd[0]), 32'b0101);
      chk("cont.d2", 32'(vd[1]), 32'b1101);
      chk("cont.d3", 32'(vd[2]), 32'b1100);
    end
`endif

    // randomized traffic on both instances; reference checks every cycle
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int j = 0; j < 2; j++) begin
        st[j] = ($urandom_range(3) == 0);
        if ($urandom_range(5) == 0) dv[j] = 4'($urandom);
      end
      rst = ($urandom_range(39) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
